// File: rtl/mux64_bits.sv
// rtl/mux64_bits.sv - registered two-source mux with byte/half/word/full sign or zero extension
module mux64_bits #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Data_RAM,
    input  logic [WIDTH-1:0] Data_CPU,
    input  logic             seleccion,
    input  logic             en,
    input  logic [1:0]       size,
    input  logic             sign_ext,
    output logic [WIDTH-1:0] Data_OutMux64,
    output logic             out_valid,
    output logic             out_src
);

    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] fmt_data;
    logic             fill;

    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;
    logic             src_d, src_q;

    always_comb begin
        sel_data = seleccion ? Data_CPU : Data_RAM;
        fill     = 1'b0;
        fmt_data = sel_data;
        case (size)
            2'd0: begin
                fill     = sign_ext & sel_data[7];
                fmt_data = {{(WIDTH-8){fill}}, sel_data[7:0]};
            end
            2'd1: begin
                fill     = sign_ext & sel_data[15];
                fmt_data = {{(WIDTH-16){fill}}, sel_data[15:0]};
            end
            2'd2: begin
                fill     = sign_ext & sel_data[31];
                fmt_data = {{(WIDTH-32){fill}}, sel_data[31:0]};
            end
            default: fmt_data = sel_data;
        endcase
    end

    // Data and source hold when not enabled; valid is a one-cycle strobe per capture.
    always_comb begin
        data_d  = data_q;
        src_d   = src_q;
        valid_d = en;
        if (en) begin
            data_d = fmt_data;
            src_d  = seleccion;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            src_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            src_q   <= src_d;
        end
    end

    assign Data_OutMux64 = data_q;
    assign out_valid     = valid_q;
    assign out_src       = src_q;

endmodule

// File: tb/tb_mux64_bits.sv
// tb/tb_mux64_bits.sv - scoreboard bench for mux64_bits with directed vectors
module tb_mux64_bits;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] Data_RAM = '0;
    logic [63:0] Data_CPU = '0;
    logic        seleccion = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  size = 2'd3;
    logic        sign_ext = 1'b0;
    logic [63:0] Data_OutMux64;
    logic        out_valid;
    logic        out_src;

    int n_tests = 0;
    int n_fail  = 0;

    logic [64:0] exp_q[$];
    logic [63:0] last_data;
    logic        last_src;

    always #5 clk = ~clk;

    mux64_bits #(.WIDTH(64)) dut (
        .clk(clk),
        .reset(reset),
        .Data_RAM(Data_RAM),
        .Data_CPU(Data_CPU),
        .seleccion(seleccion),
        .en(en),
        .size(size),
        .sign_ext(sign_ext),
        .Data_OutMux64(Data_OutMux64),
        .out_valid(out_valid),
        .out_src(out_src)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Monitor: every presented result must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [64:0] e;
        if (!reset && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", Data_OutMux64, e[64:1]);
                check("sb_src", 64'(out_src), 64'(e[0]));
            end
        end
    end

    task automatic cap(input logic [63:0] ram, input logic [63:0] cpu, input logic sel,
                       input logic [1:0] sz, input logic sx, input logic [63:0] exp);
        Data_RAM  = ram;
        Data_CPU  = cpu;
        seleccion = sel;
        size      = sz;
        sign_ext  = sx;
        en        = 1'b1;
        exp_q.push_back({exp, sel});
        last_data = exp;
        last_src  = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string name);
        en = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_valid_low"}, 64'(out_valid), 64'd0);
        check({name, "_data_hold"}, Data_OutMux64, last_data);
        check({name, "_src_hold"}, 64'(out_src), 64'(last_src));
    endtask

    initial begin
        Data_RAM = 64'hDEAD_BEEF_0000_0001;
        Data_CPU = 64'h0123_4567_89AB_CDEF;
        seleccion = 1'b1;
        en = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("reset_data", Data_OutMux64, 64'd0);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_src", 64'(out_src), 64'd0);
        @(posedge clk);
        #1;
        check("reset_prio_valid", 64'(out_valid), 64'd0);
        check("reset_prio_data", Data_OutMux64, 64'd0);
        en = 1'b0;
        reset = 1'b0;
        last_data = '0;
        last_src  = 1'b0;

        cap(64'd16, 64'd75, 1'b0, 2'd3, 1'b0, 64'd16);
        cap(64'd16, 64'd75, 1'b1, 2'd3, 1'b0, 64'd75);
        check("b2b_valid", 64'(out_valid), 64'd1);
        cap(64'd27, 64'd75, 1'b0, 2'd3, 1'b0, 64'd27);
        Data_RAM = 64'd556;
        idle("hold27");

        cap(64'd0, 64'h80, 1'b1, 2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80);
        cap(64'd0, 64'h80, 1'b1, 2'd0, 1'b0, 64'h0000_0000_0000_0080);
        cap(64'h1234_5678_8000_0000, 64'd0, 1'b0, 2'd2, 1'b1, 64'hFFFF_FFFF_8000_0000);
        cap(64'h1234_5678_8000_0000, 64'd0, 1'b0, 2'd2, 1'b0, 64'h0000_0000_8000_0000);
        cap(64'd0, 64'hAAAA_5555_0000_8001, 1'b1, 2'd1, 1'b1, 64'hFFFF_FFFF_FFFF_8001);
        cap(64'd0, 64'hAAAA_5555_0000_8001, 1'b1, 2'd1, 1'b0, 64'h0000_0000_0000_8001);
        cap(64'h8000_0000_0000_0001, 64'd0, 1'b0, 2'd3, 1'b1, 64'h8000_0000_0000_0001);
        cap(64'hFFFF_FFFF_FFFF_FF7F, 64'd0, 1'b0, 2'd0, 1'b1, 64'h0000_0000_0000_007F);
        idle("after_fmt");

        cap(64'd16, 64'd75, 1'b0, 2'd3, 1'b0, 64'd16);
        #5;
        Data_RAM  = 64'd16;
        Data_CPU  = 64'd75;
        seleccion = 1'b1;
        size      = 2'd3;
        en        = 1'b1;
        reset     = 1'b1;
        #1;
        check("mid_reset_data", Data_OutMux64, 64'd0);
        check("mid_reset_valid", 64'(out_valid), 64'd0);
        check("mid_reset_src", 64'(out_src), 64'd0);
        @(posedge clk);
        #1;
        check("held_reset_data", Data_OutMux64, 64'd0);
        check("held_reset_valid", 64'(out_valid), 64'd0);
        reset = 1'b0;
        cap(64'd16, 64'd75, 1'b1, 2'd3, 1'b0, 64'd75);
        check("post_reset_data", Data_OutMux64, 64'd75);
        check("post_reset_valid", 64'(out_valid), 64'd1);
        idle("end");
        idle("end2");

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux64_bits.md
MUX64_BITS -- requirements
Module: mux64_bits

Interface
REQ-001: Parameter WIDTH, default 64, data path width in bits; SHALL be a multiple of 8 and at least 64.
REQ-002: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003: reset  input  1  asynchronous, active-high reset.
REQ-004: Data_RAM  input  WIDTH  candidate source 0 (RAM read data).
REQ-005: Data_CPU  input  WIDTH  candidate source 1 (CPU write data).
REQ-006: seleccion  input  1  source select; 0 selects Data_RAM, 1 selects Data_CPU.
REQ-007: en  input  1  capture enable; when 1, the selected and formatted data is registered.
REQ-008: size  input  2  access size; 0 = byte, 1 = halfword (16 b), 2 = word (32 b), 3 = full WIDTH.
REQ-009: sign_ext  input  1  when 1, narrow sizes are sign-extended; when 0, they are zero-extended.
REQ-010: Data_OutMux64  output  WIDTH  registered mux result.
REQ-011: out_valid  output  1  high for exactly the cycle after each enabled capture.
REQ-012: out_src  output  1  registered copy of seleccion at the last capture.

Function
REQ-013: The combinational selection SHALL be Data_RAM when seleccion = 0 and Data_CPU when seleccion = 1.
REQ-014: Formatting for size 3 SHALL pass the selected value unchanged across all WIDTH bits.
REQ-015: Formatting for sizes 0, 1 and 2 SHALL keep the low 8, 16 or 32 bits respectively.
REQ-016: For sizes 0-2, upper bits SHALL be filled with the MSB of the kept field when sign_ext = 1.
REQ-017: For sizes 0-2, upper bits SHALL be filled with 0 when sign_ext = 0.
REQ-018: sign_ext SHALL be ignored when size = 3.
REQ-019: On a rising clk edge with en = 1, Data_OutMux64 SHALL load the formatted value.
REQ-020: On the same edge, out_src SHALL load seleccion and out_valid SHALL be set to 1.
REQ-021: Latency from input sample to output SHALL be exactly one clock cycle.
REQ-022: On a rising clk edge with en = 0, Data_OutMux64 and out_src SHALL hold their values and out_valid SHALL be 0.
REQ-023: Input changes between clock edges SHALL have no effect on the outputs; there is no combinational path from input to output.
REQ-024: Back-to-back enabled cycles SHALL each produce a new result with out_valid held continuously at 1.
REQ-025: seleccion, size and sign_ext SHALL all be sampled at the same edge as the data; changing them mid-stream SHALL affect only captures from that edge onward.
REQ-026: The only state SHALL be the three output registers; there is no state machine.

Reset
REQ-027: While reset = 1, regardless of clk, Data_OutMux64 SHALL be 0, out_valid 0 and out_src 0.
REQ-028: Reset asserted mid-stream SHALL clear the outputs immediately and discard the capture in progress.
REQ-029: The first capture SHALL occur at the first rising clk edge with reset = 0 and en = 1.
REQ-030: Reset SHALL take priority over en at the same edge.

Verification
REQ-031: Bench SHALL assert reset with inputs nonzero -> all outputs 0 immediately, without waiting for a clock edge.
REQ-032: Bench SHALL apply Data_RAM = 16, Data_CPU = 75, size = 3, en = 1, with seleccion = 0 then seleccion = 1 on consecutive cycles -> outputs 16 then 75, with out_src 0 then 1 and out_valid high both cycles.
REQ-033: Bench SHALL apply Data_RAM = 27, seleccion = 0, en = 1 for one cycle, then en = 0 with Data_RAM = 556 -> output stays 27 and out_valid = 1 then 0.
REQ-034: Bench SHALL apply Data_CPU = 0x0000_0000_0000_0080, seleccion = 1, size = 0, en = 1 -> output 0xFFFF_FFFF_FFFF_FF80 with sign_ext = 1, and 0x0000_0000_0000_0080 with sign_ext = 0.
REQ-035: Bench SHALL apply Data_RAM = 0x1234_5678_8000_0000, seleccion = 0, size = 2, sign_ext = 1, en = 1 -> output 0xFFFF_FFFF_8000_0000.
REQ-036: Bench SHALL assert reset between two enabled captures of 16 and 75 -> output forced to 0, then 75 appears one cycle after reset is released with en = 1.
